// File: rtl/controller_sequencer_pkg.sv
// Shared constants for the SAP-1 style controller/sequencer: opcodes, T-states,
// control-word bit positions and the all-inactive control word.
package controller_sequencer_pkg;

  localparam int CW_W = 12;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  // Encoding doubles as the t_state output value (HALT reads as 0).
  typedef enum logic [2:0] {
    S_HALT = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_T4   = 3'd4,
    S_T5   = 3'd5,
    S_T6   = 3'd6
  } state_t;

  localparam int CW_CP   = 11;
  localparam int CW_EP   = 10;
  localparam int CW_LM_N = 9;
  localparam int CW_CE_N = 8;
  localparam int CW_LI_N = 7;
  localparam int CW_EI_N = 6;
  localparam int CW_LA_N = 5;
  localparam int CW_EA   = 4;
  localparam int CW_SU   = 3;
  localparam int CW_EU   = 2;
  localparam int CW_LB_N = 1;
  localparam int CW_LO_N = 0;

  localparam logic [CW_W-1:0] CW_INACTIVE = 12'h3E3;

endpackage

// File: rtl/controller_sequencer_decode.sv
// Combinational control-word decode from (T-state, opcode). Opcode is only
// consulted in T4..T6.
module controller_decode
  import controller_sequencer_pkg::*;
(
  input  state_t          state,
  input  logic [3:0]      opcode,
  output logic [CW_W-1:0] cw
);

  always_comb begin
    cw = CW_INACTIVE;
    case (state)
      S_T1: begin cw[CW_EP] = 1'b1; cw[CW_LM_N] = 1'b0; end
      S_T2: cw[CW_CP] = 1'b1;
      S_T3: begin cw[CW_CE_N] = 1'b0; cw[CW_LI_N] = 1'b0; end
      S_T4: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB: begin cw[CW_EI_N] = 1'b0; cw[CW_LM_N] = 1'b0; end
          OP_OUT: begin cw[CW_EA] = 1'b1; cw[CW_LO_N] = 1'b0; end
          default: ;
        endcase
      end
      S_T5: begin
        case (opcode)
          OP_LDA: begin cw[CW_CE_N] = 1'b0; cw[CW_LA_N] = 1'b0; end
          OP_ADD, OP_SUB: begin cw[CW_CE_N] = 1'b0; cw[CW_LB_N] = 1'b0; end
          default: ;
        endcase
      end
      S_T6: begin
        if (opcode == OP_ADD || opcode == OP_SUB) begin
          cw[CW_EU]   = 1'b1;
          cw[CW_LA_N] = 1'b0;
          cw[CW_SU]   = (opcode == OP_SUB);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/controller_sequencer.sv
// Ring-counter sequencer T1..T6 with absorbing HALT; outputs forced inactive
// while reset is held.
module controller_sequencer
  import controller_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] opcode,
  output logic       cp,
  output logic       ep,
  output logic       lm_n,
  output logic       ce_n,
  output logic       li_n,
  output logic       ei_n,
  output logic       la_n,
  output logic       ea,
  output logic       su,
  output logic       eu,
  output logic       lb_n,
  output logic       lo_n,
  output logic [2:0] t_state,
  output logic       halted,
  output logic       instr_done
);

  state_t          state, state_nxt;
  logic            run;
  logic [CW_W-1:0] cw_dec, cw;

  // run holds T1 across the first edge after release, so T1 always gets a full cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_T1;
      run   <= 1'b0;
    end else begin
      state <= state_nxt;
      run   <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_T1:    state_nxt = run ? S_T2 : S_T1;
      S_T2:    state_nxt = S_T3;
      S_T3:    state_nxt = S_T4;
      S_T4:    state_nxt = (opcode == OP_HLT) ? S_HALT : S_T5;
      S_T5:    state_nxt = S_T6;
      S_T6:    state_nxt = S_T1;
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_T1;
    endcase
  end

  controller_decode u_decode (
    .state  (state),
    .opcode (opcode),
    .cw     (cw_dec)
  );

  always_comb begin
    cw         = rst_n ? cw_dec : CW_INACTIVE;
    t_state    = state;
    halted     = rst_n && (state == S_HALT);
    instr_done = rst_n && (state == S_T6);
  end

  assign cp   = cw[CW_CP];
  assign ep   = cw[CW_EP];
  assign lm_n = cw[CW_LM_N];
  assign ce_n = cw[CW_CE_N];
  assign li_n = cw[CW_LI_N];
  assign ei_n = cw[CW_EI_N];
  assign la_n = cw[CW_LA_N];
  assign ea   = cw[CW_EA];
  assign su   = cw[CW_SU];
  assign eu   = cw[CW_EU];
  assign lb_n = cw[CW_LB_N];
  assign lo_n = cw[CW_LO_N];

endmodule

// File: tb/tb_controller_sequencer.sv
// Directed bench for controller_sequencer: per-T-state control words against
// hand-computed constants, plus a W-bus single-driver check every cycle.
module tb_controller_sequencer;

  // {cp,ep,lm_n,ce_n,li_n,ei_n,la_n,ea,su,eu,lb_n,lo_n}
  localparam logic [11:0] W_INACT  = 12'h3E3;
  localparam logic [11:0] W_T1     = 12'h5E3;
  localparam logic [11:0] W_T2     = 12'hBE3;
  localparam logic [11:0] W_T3     = 12'h263;
  localparam logic [11:0] W_T4_MEM = 12'h1A3;
  localparam logic [11:0] W_T4_OUT = 12'h3F2;
  localparam logic [11:0] W_T5_LDA = 12'h2C3;
  localparam logic [11:0] W_T5_ALU = 12'h2E1;
  localparam logic [11:0] W_T6_ADD = 12'h3C7;
  localparam logic [11:0] W_T6_SUB = 12'h3CF;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] opcode;
  logic       cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu, lb_n, lo_n;
  logic [2:0] t_state;
  logic       halted, instr_done;
  logic [11:0] cw;
  int n_chk = 0;
  int n_err = 0;

  controller_sequencer dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode),
    .cp(cp), .ep(ep), .lm_n(lm_n), .ce_n(ce_n), .li_n(li_n), .ei_n(ei_n),
    .la_n(la_n), .ea(ea), .su(su), .eu(eu), .lb_n(lb_n), .lo_n(lo_n),
    .t_state(t_state), .halted(halted), .instr_done(instr_done)
  );

  always #5 clk = ~clk;

  assign cw = {cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu, lb_n, lo_n};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // At most one W-bus driver in any cycle.
  always @(negedge clk) begin
    int n;
    n = int'(ep) + int'(!ce_n) + int'(!ei_n) + int'(ea) + int'(eu);
    chk("bus_one_hot", (n > 1), 0);
  end

  task automatic state_chk(input string tag, input logic [11:0] w, input logic [2:0] ts,
                           input logic done);
    chk({tag, "_cw"}, cw, w);
    chk({tag, "_ts"}, t_state, ts);
    chk({tag, "_done"}, instr_done, done);
    chk({tag, "_halt"}, halted, 1'b0);
  endtask

  // Entered at a negedge in T1; leaves at the negedge of the next T1 (or in T4 for HLT).
  task automatic run_instr(input string tag, input logic [3:0] op, input logic [11:0] w4,
                           input logic [11:0] w5, input logic [11:0] w6);
    state_chk({tag, "_t1"}, W_T1, 3'd1, 1'b0);
    opcode = 4'($urandom);
    @(negedge clk); state_chk({tag, "_t2"}, W_T2, 3'd2, 1'b0);
    opcode = 4'($urandom);
    @(negedge clk); state_chk({tag, "_t3"}, W_T3, 3'd3, 1'b0);
    opcode = op;
    @(negedge clk); state_chk({tag, "_t4"}, w4, 3'd4, 1'b0);
    if (op != 4'b1111) begin
      @(negedge clk); state_chk({tag, "_t5"}, w5, 3'd5, 1'b0);
      @(negedge clk); state_chk({tag, "_t6"}, w6, 3'd6, 1'b1);
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1);
  end

  initial begin
    rst_n  = 1'b0;
    opcode = 4'b0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    state_chk("rst", W_INACT, 3'd1, 1'b0);
    rst_n = 1'b1;
    #1 chk("rel_cw", cw, W_T1);
    @(negedge clk);  // first edge after release holds T1

    run_instr("lda", 4'b0000, W_T4_MEM, W_T5_LDA, W_INACT);
    run_instr("add", 4'b0001, W_T4_MEM, W_T5_ALU, W_T6_ADD);
    run_instr("sub", 4'b0010, W_T4_MEM, W_T5_ALU, W_T6_SUB);
    run_instr("nop", 4'b0101, W_INACT,  W_INACT,  W_INACT);
    run_instr("out", 4'b1110, W_T4_OUT, W_INACT,  W_INACT);
    run_instr("hlt", 4'b1111, W_INACT,  W_INACT,  W_INACT);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      opcode = 4'($urandom);
      chk("halt_cw", cw, W_INACT);
      chk("halt_ts", t_state, 3'd0);
      chk("halt_flag", halted, 1'b1);
      chk("halt_done", instr_done, 1'b0);
    end

    // reset out of HALT is immediate
    rst_n = 1'b0;
    #1;
    chk("hrst_ts", t_state, 3'd1);
    chk("hrst_halt", halted, 1'b0);
    chk("hrst_cw", cw, W_INACT);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // ADD interrupted by an asynchronous reset pulse mid-T5
    chk("mid_t1", cw, W_T1);
    @(negedge clk); chk("mid_t2", cw, W_T2);
    @(negedge clk); chk("mid_t3", cw, W_T3);
    opcode = 4'b0001;
    @(negedge clk); chk("mid_t4", cw, W_T4_MEM);
    @(negedge clk); chk("mid_t5", cw, W_T5_ALU);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cw", cw, W_INACT);
    chk("mid_rst_ts", t_state, 3'd1);
    #1 rst_n = 1'b1;
    #1 chk("mid_rel_cw", cw, W_T1);
    @(negedge clk);
    run_instr("add2", 4'b0001, W_T4_MEM, W_T5_ALU, W_T6_ADD);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/controller_sequencer.md
CONTROLLER_SEQUENCER -- requirements
Module: controller_sequencer

Interface
REQ-001 The block SHALL use one clock and a reset that is asynchronous and active-low, with ports named clk and rst_n.
REQ-002 Port: clk  input  1  system clock; all state changes on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: opcode  input  4  instruction-register upper nibble; valid from T4 to T6.
REQ-005 Port: cp  output  1  program-counter increment enable, active-high.
REQ-006 Port: ep  output  1  program-counter drive onto W bus, active-high.
REQ-007 Port: lm_n  output  1  memory-address-register load, active-low.
REQ-008 Port: ce_n  output  1  16x8 RAM cell enable onto W bus, active-low.
REQ-009 Port: li_n / ei_n  output  1 each  instruction-register load / drive address nibble, active-low.
REQ-010 Port: la_n / ea  output  1 each  accumulator load (active-low) / drive (active-high).
REQ-011 Port: su / eu  output  1 each  ALU subtract select / ALU drive, active-high.
REQ-012 Port: lb_n / lo_n  output  1 each  B-register load / output-register load, active-low.
REQ-013 Port: t_state  output  3  current T-state (1..6), 0 when halted.
REQ-014 Port: halted  output  1  high while in HALT.
REQ-015 Port: instr_done  output  1  high during T6 of every non-HLT instruction.

Function
REQ-016 In the inactive control word, cp, ep, ea, su and eu SHALL be 0, and lm_n, ce_n, li_n, ei_n, la_n, lb_n and lo_n SHALL be 1.
REQ-017 The state machine SHALL have the states T1..T6 and HALT; T1 advances to T2 through T6, and T6 returns to T1, each on a rising edge.
REQ-018 Fetch SHALL be: T1 asserts ep and lm_n; T2 asserts cp; T3 asserts ce_n and li_n.
REQ-019 For LDA (0000), T4 SHALL assert ei_n and lm_n, T5 SHALL assert ce_n and la_n, and T6 SHALL be inactive.
REQ-020 For ADD (0001), T4 SHALL assert ei_n and lm_n, T5 SHALL assert ce_n and lb_n, and T6 SHALL assert eu and la_n with su=0.
REQ-021 For SUB (0010), the sequence SHALL equal ADD except that su=1 in T6 only.
REQ-022 For OUT (1110), T4 SHALL assert ea and lo_n, and T5 and T6 SHALL be inactive.
REQ-023 For HLT (1111), T4 SHALL output an inactive word and the next edge SHALL enter HALT.
REQ-024 HALT SHALL be absorbing, with an inactive word, halted=1 and t_state=0, left only by reset.
REQ-025 Opcodes 0011-1101 SHALL be NOPs, with an inactive word during T4-T6 and normal progression to T1.
REQ-026 Control outputs SHALL be a combinational function of the state and opcode only, with no output latency beyond the state register.
REQ-027 At most one W-bus driver (ep, ce_n low, ei_n low, ea, eu) SHALL be active in any cycle, under all opcodes.
REQ-028 Opcode SHALL be ignored during T1-T3, so an X or changing opcode there has no effect.

Reset
REQ-029 rst_n low SHALL force state T1 immediately, regardless of clk, at any point including mid-instruction and HALT.
REQ-030 While rst_n is low, all control outputs SHALL be inactive, halted=0, instr_done=0 and t_state=1.
REQ-031 The first rising edge after rst_n rises SHALL still be in T1, so the T1 word is present for one full cycle before advancing.

Structure
REQ-032 A shared package SHALL hold the opcode constants (LDA, ADD, SUB, OUT, HLT), the state enumeration, the control-word bit indices and the inactive-word constant.
REQ-033 One combinational sub-module, controller_decode, SHALL map (state, opcode) to the 12-bit control word.
REQ-034 The top level SHALL hold only the state register, next-state logic and reset gating.

Verification
REQ-035 Assert rst_n=0 for 3 cycles, then release -> inactive word with t_state=1 during reset, then T1 word (ep=1, lm_n=0) for one cycle and T2 (cp=1) next.
REQ-036 Opcode 0000 -> T4 ei_n=0 and lm_n=0, T5 ce_n=0 and la_n=0, T6 inactive with instr_done=1, then T1.
REQ-037 Opcodes 0001 then 0010 -> T5 lb_n=0 for both; T6 eu=1 and la_n=0 for both, with su=0 for ADD and su=1 for SUB.
REQ-038 Opcode 1110 then 1111 -> OUT T4 ea=1 and lo_n=0; after HLT T4, halted=1 and t_state=0 held for 20 cycles with all outputs inactive.
REQ-039 Opcode 0101 -> inactive T4-T6, then return to T1; a bus-driver one-hot checker passes throughout all tests.
REQ-040 Pulse rst_n low mid-T5 of ADD, asynchronously between edges -> outputs go inactive immediately and sequencing restarts at T1.
